// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : MEM-stage initiator for the word-wide data RAM. Turns byte,
//               halfword and word loads/stores into word-only RAM accesses.
//               Sub-word stores use read-modify-write. Loads are lane-extracted
//               and sign/zero extended. Big-endian: byte offset 0 = [31:24].
//               Optional alignment checking is enabled by defining
//               DATA_MEM_CTRL_ALIGN_CHECK_EN. Without it, the address bits below
//               the access size are ignored and misalign_o stays 0.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [2:0]        op_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              done_o,
    output logic              misalign_o,
    output logic              stall_req_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    input  logic [31:0]       mem_data_i
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_SB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_SW  = 3'b110;
    localparam logic [2:0] OP_SH  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              state_q;
    logic [2:0]          op_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rbuf_q;
    logic                err_q;
    logic [31:0]         rdata_q;
    logic                done_q;

    logic                misalign_d;
    logic                store_q;
    logic [7:0]          byte_d;
    logic [15:0]         half_d;
    logic [31:0]         load_ext_d;
    logic [31:0]         wr_data_d;
    logic                unused_addr_hi;

    // Address bits above the RAM range select nothing.
    assign unused_addr_hi = ^addr_i[31:ADDR_W+2];

    // Alignment check on the incoming request (only meaningful in IDLE).
`ifdef DATA_MEM_CTRL_ALIGN_CHECK_EN
    always_comb begin
        misalign_d = 1'b0;
        case (op_i)
            OP_LH, OP_LHU, OP_SH: misalign_d = addr_i[0];
            OP_LW, OP_SW:         misalign_d = |addr_i[1:0];
            default:              misalign_d = 1'b0;
        endcase
    end
`else
    assign misalign_d = 1'b0;
`endif

    assign store_q = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);

    // Lane extraction and extension of the RAM read word for loads.
    always_comb begin
        byte_d     = 8'h00;
        half_d     = 16'h0000;
        load_ext_d = mem_data_i;
        case (addr_q[1:0])
            2'b00:   byte_d = mem_data_i[31:24];
            2'b01:   byte_d = mem_data_i[23:16];
            2'b10:   byte_d = mem_data_i[15:8];
            default: byte_d = mem_data_i[7:0];
        endcase
        half_d = addr_q[1] ? mem_data_i[15:0] : mem_data_i[31:16];
        case (op_q)
            OP_LB:   load_ext_d = {{24{byte_d[7]}}, byte_d};
            OP_LBU:  load_ext_d = {24'h000000, byte_d};
            OP_LH:   load_ext_d = {{16{half_d[15]}}, half_d};
            OP_LHU:  load_ext_d = {16'h0000, half_d};
            default: load_ext_d = mem_data_i;
        endcase
    end

    // Write word: full store data for SW, otherwise rbuf with one lane replaced.
    always_comb begin
        wr_data_d = wdata_q;
        if (op_q == OP_SB) begin
            wr_data_d = rbuf_q;
            case (addr_q[1:0])
                2'b00:   wr_data_d[31:24] = wdata_q[7:0];
                2'b01:   wr_data_d[23:16] = wdata_q[7:0];
                2'b10:   wr_data_d[15:8]  = wdata_q[7:0];
                default: wr_data_d[7:0]   = wdata_q[7:0];
            endcase
        end else if (op_q == OP_SH) begin
            wr_data_d = addr_q[1] ? {rbuf_q[31:16], wdata_q[15:0]}
                                  : {wdata_q[15:0], rbuf_q[15:0]};
        end
    end

    // Access FSM with registered completion, error and load-result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rbuf_q  <= 32'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        op_q    <= op_i;
                        addr_q  <= addr_i[ADDR_W+1:0];
                        wdata_q <= wdata_i;
                        err_q   <= misalign_d;
                        if (misalign_d) begin
                            state_q <= S_RESP;
                            done_q  <= 1'b1;
                        end else if (op_i == OP_SW) begin
                            state_q <= S_WR;
                        end else begin
                            state_q <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    rbuf_q <= mem_data_i;
                    if (store_q) begin
                        state_q <= S_WR;
                    end else begin
                        state_q <= S_RESP;
                        done_q  <= 1'b1;
                        rdata_q <= load_ext_d;
                    end
                end
                S_WR: begin
                    state_q <= S_RESP;
                    done_q  <= 1'b1;
                end
                default: begin
                    // RESP: request input is ignored; error flag lives one cycle.
                    state_q <= S_IDLE;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    // RAM strobes follow the state; reset suppresses a write in flight.
    always_comb begin
        mem_ce_o   = !rst && ((state_q == S_RD) || (state_q == S_WR));
        mem_we_o   = !rst && (state_q == S_WR);
        mem_addr_o = mem_ce_o ? addr_q[ADDR_W+1:2] : '0;
        mem_data_o = mem_ce_o ? wr_data_d : 32'h0;
    end

    assign stall_req_o = ((state_q == S_IDLE) && req_i) ||
                         (state_q == S_RD) || (state_q == S_WR);
    assign rdata_o     = rdata_q;
    assign done_o      = done_q;
    assign misalign_o  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Self-checking bench for data_mem_ctrl with a behavioural RAM.
//               Table of directed accesses plus hand sequences for the
//               misaligned request and reset during a read-modify-write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

    localparam int         ADDR_W = 17;
    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_SB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_SW  = 3'b110;
    localparam logic [2:0] OP_SH  = 3'b111;

    logic              clk;
    logic              rst;
    logic              req_i;
    logic [2:0]        op_i;
    logic [31:0]       addr_i;
    logic [31:0]       wdata_i;
    logic [31:0]       rdata_o;
    logic              done_o;
    logic              misalign_o;
    logic              stall_req_o;
    logic              mem_ce_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_data_o;
    logic [31:0]       mem_data_i;

    logic [31:0] ram [0:63];

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .op_i        (op_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .done_o      (done_o),
        .misalign_o  (misalign_o),
        .stall_req_o (stall_req_o),
        .mem_ce_o    (mem_ce_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural word RAM: combinational read, write on the clock edge.
    assign mem_data_i = ram[mem_addr_o[5:0]];
    always @(posedge clk) begin
        if (mem_ce_o && mem_we_o) ram[mem_addr_o[5:0]] <= mem_data_o;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_waddr;
        logic [31:0] exp_wdat;
    } vec_t;

    vec_t vecs [0:15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request from IDLE and observe it until done_o (bounded).
    task automatic run_access(input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wd,
                              output int lat, output int rdc, output int wrc,
                              output logic [31:0] waddr, output logic [31:0] wdat,
                              output logic mis, output int stalls);
        lat = -1; rdc = 0; wrc = 0; waddr = 32'h0; wdat = 32'h0; mis = 1'b0;
        stalls = 0;
        req_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wd;
        #1;
        if (stall_req_o) stalls++;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (mem_ce_o && !mem_we_o) rdc++;
            if (mem_ce_o && mem_we_o) begin
                wrc++;
                waddr = 32'(mem_addr_o);
                wdat  = mem_data_o;
            end
            if (stall_req_o) stalls++;
            if (done_o) begin
                lat = k;
                mis = misalign_o;
                break;
            end
        end
        req_i = 1'b0;
        @(posedge clk); #1;
        check("done_single_pulse", 32'(done_o), 32'h0);
    endtask

    int          lat, rdc, wrc, stalls;
    logic [31:0] waddr, wdat;
    logic        mis;
    logic        saw_done;

    initial begin
        vecs[0]  = '{OP_LB,  32'h10, 32'h0,        32'hFFFFFF88, 2, 1, 0, 32'h0, 32'h0};
        vecs[1]  = '{OP_LBU, 32'h13, 32'h0,        32'h000000BB, 2, 1, 0, 32'h0, 32'h0};
        vecs[2]  = '{OP_LH,  32'h12, 32'h0,        32'hFFFFAABB, 2, 1, 0, 32'h0, 32'h0};
        vecs[3]  = '{OP_LHU, 32'h10, 32'h0,        32'h00008899, 2, 1, 0, 32'h0, 32'h0};
        vecs[4]  = '{OP_LW,  32'h10, 32'h0,        32'h8899AABB, 2, 1, 0, 32'h0, 32'h0};
        vecs[5]  = '{OP_LB,  32'h12, 32'h0,        32'hFFFFFFAA, 2, 1, 0, 32'h0, 32'h0};
        vecs[6]  = '{OP_LHU, 32'h12, 32'h0,        32'h0000AABB, 2, 1, 0, 32'h0, 32'h0};
        vecs[7]  = '{OP_SB,  32'h11, 32'h12345655, 32'h0000AABB, 3, 1, 1, 32'h4, 32'h8855AABB};
        vecs[8]  = '{OP_LW,  32'h10, 32'h0,        32'h8855AABB, 2, 1, 0, 32'h0, 32'h0};
        vecs[9]  = '{OP_LB,  32'h11, 32'h0,        32'h00000055, 2, 1, 0, 32'h0, 32'h0};
        vecs[10] = '{OP_SW,  32'h20, 32'hDEADBEEF, 32'h00000055, 2, 0, 1, 32'h8, 32'hDEADBEEF};
        vecs[11] = '{OP_LW,  32'h20, 32'h0,        32'hDEADBEEF, 2, 1, 0, 32'h0, 32'h0};
        vecs[12] = '{OP_SH,  32'h22, 32'h1234CAFE, 32'hDEADBEEF, 3, 1, 1, 32'h8, 32'hDEADCAFE};
        vecs[13] = '{OP_SB,  32'h23, 32'h00000077, 32'hDEADBEEF, 3, 1, 1, 32'h8, 32'hDEADCA77};
        vecs[14] = '{OP_LW,  32'h20, 32'h0,        32'hDEADCA77, 2, 1, 0, 32'h0, 32'h0};
        vecs[15] = '{OP_LBU, 32'h21, 32'h0,        32'h000000AD, 2, 1, 0, 32'h0, 32'h0};

        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        ram[4] = 32'h8899AABB;
        ram[8] = 32'h11223344;

        rst = 1'b1; req_i = 1'b0; op_i = 3'b000; addr_i = 32'h0; wdata_i = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata",    rdata_o,             32'h0);
        check("reset_done",     32'(done_o),         32'h0);
        check("reset_misalign", 32'(misalign_o),     32'h0);
        check("reset_stall",    32'(stall_req_o),    32'h0);
        check("reset_ce",       32'(mem_ce_o),       32'h0);
        check("reset_addr",     32'(mem_addr_o),     32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven accesses; RAM contents evolve through the table.
        for (int i = 0; i < 16; i++) begin
            run_access(vecs[i].op, vecs[i].addr, vecs[i].wdata,
                       lat, rdc, wrc, waddr, wdat, mis, stalls);
            check($sformatf("v%0d_latency", i),  32'(lat),    32'(vecs[i].exp_lat));
            check($sformatf("v%0d_stalls", i),   32'(stalls), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_rdata", i),    rdata_o,     vecs[i].exp_rdata);
            check($sformatf("v%0d_misalign", i), 32'(mis),    32'h0);
            check($sformatf("v%0d_rd_cycles", i), 32'(rdc),   32'(vecs[i].exp_rd));
            check($sformatf("v%0d_wr_cycles", i), 32'(wrc),   32'(vecs[i].exp_wr));
            if (vecs[i].exp_wr > 0) begin
                check($sformatf("v%0d_wr_addr", i), waddr, vecs[i].exp_waddr);
                check($sformatf("v%0d_wr_data", i), wdat,  vecs[i].exp_wdat);
            end
        end

        // Misaligned word store at 0x22, then misaligned halfword load at 0x11.
        run_access(OP_SW, 32'h22, 32'h01020304, lat, rdc, wrc, waddr, wdat, mis, stalls);
`ifdef DATA_MEM_CTRL_ALIGN_CHECK_EN
        check("mis_sw_latency",  32'(lat), 32'h1);
        check("mis_sw_flag",     32'(mis), 32'h1);
        check("mis_sw_no_ce",    32'(rdc + wrc), 32'h0);
        check("mis_sw_ram8",     ram[8], 32'hDEADCA77);
        run_access(OP_LH, 32'h11, 32'h0, lat, rdc, wrc, waddr, wdat, mis, stalls);
        check("mis_lh_latency",  32'(lat), 32'h1);
        check("mis_lh_flag",     32'(mis), 32'h1);
        check("mis_lh_no_ce",    32'(rdc + wrc), 32'h0);
`else
        check("mis_sw_latency",  32'(lat), 32'h2);
        check("mis_sw_flag",     32'(mis), 32'h0);
        check("mis_sw_wr_addr",  waddr,    32'h8);
        check("mis_sw_ram8",     ram[8],   32'h01020304);
        run_access(OP_LH, 32'h11, 32'h0, lat, rdc, wrc, waddr, wdat, mis, stalls);
        check("mis_lh_latency",  32'(lat), 32'h2);
        check("mis_lh_flag",     32'(mis), 32'h0);
        check("mis_lh_rdata",    rdata_o,  32'hFFFF8855);
`endif

        // Reset arriving in the WR cycle of a halfword read-modify-write.
        req_i = 1'b1; op_i = OP_SH; addr_i = 32'h10; wdata_i = 32'h0000BEEF;
        @(posedge clk); #1;
        check("rst_sh_rd_ce", 32'(mem_ce_o), 32'h1);
        check("rst_sh_rd_we", 32'(mem_we_o), 32'h0);
        @(posedge clk); #1;
        check("rst_sh_wr_we", 32'(mem_we_o), 32'h1);
        rst = 1'b1; req_i = 1'b0;
        #1;
        check("rst_sh_we_gated", 32'(mem_we_o), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_sh_ram4",   ram[4],           32'h8855AABB);
        check("rst_sh_stall",  32'(stall_req_o), 32'h0);
        check("rst_sh_done",   32'(done_o),      32'h0);
        check("rst_sh_rdata",  rdata_o,          32'h0);
        saw_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (done_o) saw_done = 1'b1;
        end
        check("rst_sh_no_done", 32'(saw_done), 32'h0);

        run_access(OP_LW, 32'h10, 32'h0, lat, rdc, wrc, waddr, wdat, mis, stalls);
        check("post_rst_lw_latency", 32'(lat), 32'h2);
        check("post_rst_lw_rdata",   rdata_o,  32'h8855AABB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
